// File: rtl/sram_like_responder.sv
// SRAM-like target: accepts requests with addr_ok, commits writes at accept and
// returns in-order responses with data_ok after a programmable latency.
module sram_like_responder #(
  parameter int MEM_AW      = 10,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  input  logic        stall_addr,
  input  logic        stall_data
);

  localparam int          DEPTH  = 1 << MEM_AW;
  localparam int          SLOTS  = 4;
  localparam logic [2:0]  OUT_N  = 3'(OUTSTANDING);
  localparam logic [1:0]  LAST_P = 2'(OUTSTANDING - 1);
  localparam logic [3:0]  T_INIT = 4'(LATENCY - 1);

  logic [31:0]       mem [DEPTH];
  logic [MEM_AW-1:0] idx;
  logic [31:0]       rd_word;
  logic              accept;
  logic              retire;

  // Slots beyond OUTSTANDING exist only so 2-bit pointers index cleanly.
  logic              q_vld_q  [SLOTS];
  logic              q_vld_d  [SLOTS];
  logic              q_wr_q   [SLOTS];
  logic              q_wr_d   [SLOTS];
  logic [31:0]       q_data_q [SLOTS];
  logic [31:0]       q_data_d [SLOTS];
  logic [3:0]        q_tmr_q  [SLOTS];
  logic [3:0]        q_tmr_d  [SLOTS];
  logic [1:0]        head_q, head_d;
  logic [1:0]        tail_q, tail_d;
  logic [2:0]        count_q, count_d;
  logic              data_ok_q, data_ok_d;
  logic [31:0]       rdata_q, rdata_d;

  wire unused_ok = &{1'b0, size, addr[31:MEM_AW+2], addr[1:0]};

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == LAST_P) ? 2'd0 : p + 2'd1;
  endfunction

  assign idx     = addr[MEM_AW+1:2];
  assign rd_word = mem[idx];
  // Full check uses the registered count, so a same-cycle retire frees nothing.
  assign addr_ok = resetn & req & ~stall_addr & (count_q != OUT_N);
  assign accept  = req & addr_ok;
  assign retire  = (count_q != 3'd0) & (q_tmr_q[head_q] == 4'd0) & ~stall_data;
  assign data_ok = data_ok_q;
  assign rdata   = rdata_q;

  always_comb begin
    q_vld_d   = q_vld_q;
    q_wr_d    = q_wr_q;
    q_data_d  = q_data_q;
    q_tmr_d   = q_tmr_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    data_ok_d = 1'b0;
    rdata_d   = rdata_q;

    for (int i = 0; i < SLOTS; i++) begin
      if (q_vld_q[i] && q_tmr_q[i] != 4'd0) q_tmr_d[i] = q_tmr_q[i] - 4'd1;
    end

    if (retire) begin
      q_vld_d[head_q] = 1'b0;
      head_d          = nxt(head_q);
      data_ok_d       = 1'b1;
      rdata_d         = q_wr_q[head_q] ? 32'h0 : q_data_q[head_q];
    end

    // Read data is captured before this edge's write lands in memory.
    if (accept) begin
      q_vld_d[tail_q]  = 1'b1;
      q_wr_d[tail_q]   = wr;
      q_data_d[tail_q] = wr ? 32'h0 : rd_word;
      q_tmr_d[tail_q]  = T_INIT;
      tail_d           = nxt(tail_q);
    end

    case ({accept, retire})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q    <= 2'd0;
      tail_q    <= 2'd0;
      count_q   <= 3'd0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0;
      for (int i = 0; i < SLOTS; i++) begin
        q_vld_q[i]  <= 1'b0;
        q_wr_q[i]   <= 1'b0;
        q_data_q[i] <= 32'h0;
        q_tmr_q[i]  <= 4'd0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
      q_vld_q   <= q_vld_d;
      q_wr_q    <= q_wr_d;
      q_data_q  <= q_data_d;
      q_tmr_q   <= q_tmr_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench for sram_like_responder with default parameters
// (MEM_AW 10, LATENCY 2, OUTSTANDING 2).
module tb_sram_like_responder;

  logic        clk;
  logic        resetn;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        stall_addr;
  logic        stall_data;

  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_pass;
  int          cyc;
  int          resp_cnt;
  int          last_resp_cyc;

  sram_like_responder dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .wr         (wr),
    .size       (size),
    .wstrb      (wstrb),
    .addr       (addr),
    .wdata      (wdata),
    .addr_ok    (addr_ok),
    .data_ok    (data_ok),
    .rdata      (rdata),
    .stall_addr (stall_addr),
    .stall_data (stall_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // scoreboard: every data_ok pops one expected rdata
  always @(negedge clk) begin
    if (data_ok) begin
      check("resp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("rdata", rdata, exp_q.pop_front());
      resp_cnt++;
      last_resp_cyc = cyc;
    end
  end

  // driver tasks (called just after a rising edge)
  task automatic wait_accept(input logic [31:0] exp_data, output int acc);
    acc = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (addr_ok) begin
        @(posedge clk);
        #1;
        acc = cyc;
        exp_q.push_back(exp_data);
        break;
      end
    end
    check("accepted", 32'(acc >= 0), 32'd1);
  endtask

  task automatic drive_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    req   = 1'b1;
    wr    = w;
    addr  = a;
    wdata = d;
    wstrb = s;
    size  = 2'd2;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp_data, output int acc);
    drive_req(w, a, d, s);
    wait_accept(exp_data, acc);
    req = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    @(posedge clk);
    #1;
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int acc_w, acc_r, acc3, rel, base, acc_n;
    n_checks = 0; n_pass = 0; resp_cnt = 0; last_resp_cyc = 0;
    resetn = 1'b0; req = 1'b1; wr = 1'b0; size = 2'd0; wstrb = 4'h0;
    addr = 32'h0; wdata = 32'h0; stall_addr = 1'b0; stall_data = 1'b0;

    // reset values, addr_ok forced low even with req high
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_addr_ok", {31'b0, addr_ok}, 32'd0);
    check("rst_data_ok", {31'b0, data_ok}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    req = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // write then read, read latency
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, acc_w);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, acc_r);
    check("b2b_accept", 32'(acc_r - acc_w), 32'd1);
    wait_drain();
    check("read_latency", 32'(last_resp_cyc - acc_r), 32'd2);

    // partial byte-strobe write
    issue(1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, acc_w);
    issue(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, acc_w);
    issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, acc_r);
    wait_drain();

    // queue full under stall_data
    stall_data = 1'b1;
    issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, acc_r);
    issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, acc_r);
    drive_req(1'b0, 32'h10, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("full_addr_ok", {31'b0, addr_ok}, 32'd0);
      check("stalled_data_ok", {31'b0, data_ok}, 32'd0);
    end
    @(posedge clk); #1;
    stall_data = 1'b0;
    rel = cyc;
    base = resp_cnt;
    wait_accept(32'hDEADBEEF, acc3);
    req = 1'b0;
    check("release_retire_cyc", 32'(last_resp_cyc), 32'(rel + 1));
    check("third_accept_cyc", 32'(acc3), 32'(rel + 2));
    check("resp_before_third", 32'(resp_cnt - base), 32'd1);
    wait_drain();

    // read-after-write before the write's data_ok
    issue(1'b1, 32'h40, 32'h5A5A1234, 4'hF, 32'h0, acc_w);
    issue(1'b0, 32'h40, 32'h0, 4'h0, 32'h5A5A1234, acc_r);
    check("raw_accept_gap", 32'(acc_r - acc_w), 32'd1);
    wait_drain();

    // stall_addr toggling with req held
    base = resp_cnt;
    acc_n = 0;
    for (int i = 0; i < 8; i++) begin
      stall_addr = i[0];
      drive_req(1'b0, 32'h40, 32'h0, 4'h0);
      @(negedge clk);
      check("stall_addr_gate", {31'b0, addr_ok}, {31'b0, ~stall_addr});
      if (addr_ok) begin
        exp_q.push_back(32'h5A5A1234);
        acc_n++;
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    stall_addr = 1'b0;
    wait_drain();
    check("toggle_accepts", 32'(acc_n), 32'd4);
    check("toggle_resp_cnt", 32'(resp_cnt - base), 32'(acc_n));

    // reset with two entries outstanding
    issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, acc_r);
    issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, acc_r);
    resetn = 1'b0;
    exp_q.delete();
    base = resp_cnt;
    @(negedge clk);
    check("midrst_data_ok", {31'b0, data_ok}, 32'd0);
    check("midrst_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_rst_data_ok", {31'b0, data_ok}, 32'd0);
    end
    @(posedge clk); #1;
    check("post_rst_resp_cnt", 32'(resp_cnt - base), 32'd0);
    issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, acc_r);
    // 0x1010 aliases word 4 (0x10) with a 1024-word memory
    issue(1'b0, 32'h1010, 32'h0, 4'h0, 32'hDEADBEEF, acc_r);
    wait_drain();
    check("final_resp_cnt", 32'(resp_cnt - base), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
